// File: rtl/ftb_update_sched_pkg.sv
// Shared types and constants for the FTB update scheduler and its queue.
package ftb_update_sched_pkg;

    // Width of an update block start address.
    localparam int XDEF_W = 39;

    // Default update queue depth and lookup-starvation allowance.
    localparam int FTB_UPDQ_DEPTH       = 4;
    localparam int FTB_UPD_STARVE_LIMIT = 8;

    // Commit-time FTB entry payload carried alongside the start PC.
    typedef struct packed {
        logic        valid;
        logic [11:0] tag;
        logic [19:0] tgt;
        logic [1:0]  ctr0;
        logic [1:0]  ctr1;
        logic        always_taken;
    } ftbInfo_t;

    // Scheduler states: lookups own the port (IDLE) or an update does (UPD).
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        UPD  = 1'b1
    } updSchedState_e;

    // Two updates land in the same FTB entry when their start PCs match.
    function automatic logic pc_eq(input logic [XDEF_W-1:0] a,
                                   input logic [XDEF_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/ftb_upd_fifo.sv
// Update queue storage: entry array, head/tail/count, youngest-entry PC
// compare for coalescing and a payload overwrite of the youngest entry.
module ftb_upd_fifo
    import ftb_update_sched_pkg::*;
#(
    parameter  int DEPTH = FTB_UPDQ_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              ovr,
    input  logic [XDEF_W-1:0] wr_pc,
    input  ftbInfo_t          wr_info,
    input  logic [XDEF_W-1:0] cmp_pc,
    output logic              tail_hit,
    output logic [XDEF_W-1:0] head_pc,
    output ftbInfo_t          head_info,
    output logic [CW-1:0]     count
);

    logic [XDEF_W-1:0] pc_mem   [DEPTH];
    ftbInfo_t          info_mem [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [PW-1:0]     young_idx;
    logic [CW-1:0]     count_q;

    // The youngest entry sits just behind the tail; pointers wrap naturally.
    assign young_idx = tail_q - PW'(1);
    assign tail_hit  = (count_q != '0) && pc_eq(pc_mem[young_idx], cmp_pc);
    assign head_pc   = pc_mem[head_q];
    assign head_info = info_mem[head_q];
    assign count     = count_q;

    // Entry storage: append at the tail, or refresh the youngest payload in place.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= wr_pc;
            info_mem[tail_q] <= wr_info;
        end else if (ovr) begin
            info_mem[young_idx] <= wr_info;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ftb_update_sched.sv
// Arbitrates the FTB's single port between BPU lookups and queued
// commit-time updates, and holds the prediction pipeline while an
// update owns the port.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | lookups own the port; an update is picked when lookups are
//         | idle, the queue is full, or lookups have starved updates
//   UPD   | head entry presented to the FTB until it reports finished
module ftb_update_sched
    import ftb_update_sched_pkg::*;
#(
    parameter  int QDEPTH       = FTB_UPDQ_DEPTH,
    parameter  int STARVE_LIMIT = FTB_UPD_STARVE_LIMIT,
    localparam int CW           = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_update_vld,
    output logic              o_update_rdy,
    input  logic [XDEF_W-1:0] i_update_pc,
    input  ftbInfo_t          i_update_info,
    input  logic              i_lookup_req,
    output logic              o_lookup_gnt,
    output logic              o_ftb_update_req,
    output logic [XDEF_W-1:0] o_ftb_update_pc,
    output ftbInfo_t          o_ftb_update_info,
    input  logic              i_ftb_update_finished,
    output logic              o_pred_hold,
    output logic [CW-1:0]     o_q_count
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_FULL   = CW'(QDEPTH);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [0:0]     ST_IDLE    = IDLE;
    localparam logic [0:0]     ST_UPD     = UPD;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [SW-1:0]     starve_q;
    logic [CW-1:0]     count;
    logic [XDEF_W-1:0] head_pc;
    ftbInfo_t          head_info;
    logic              tail_hit;
    logic              q_empty;
    logic              q_full;
    logic              in_idle;
    logic              in_upd;
    logic              sel_upd;
    logic              lookup_gnt;
    logic              enq;
    logic              youngest_busy;
    logic              coal;
    logic              push;
    logic              pop;

    assign q_empty = (count == '0);
    assign q_full  = (count == CNT_FULL);
    assign in_idle = (state_q == ST_IDLE);
    assign in_upd  = (state_q == ST_UPD);

    assign sel_upd    = in_idle && !q_empty &&
                        (!i_lookup_req || q_full || starve_q == STARVE_MAX);
    assign lookup_gnt = in_idle && i_lookup_req && !sel_upd;

    // Acceptance looks only at the registered count, so a pop in the same
    // cycle never opens a slot early.
    assign enq           = i_update_vld && !q_full;
    // With a single entry under UPD the youngest is the one the FTB is
    // consuming; its payload must not change underneath the FTB.
    assign youngest_busy = in_upd && (count == CW'(1));
    assign coal          = enq && tail_hit && !youngest_busy;
    assign push          = enq && !coal;
    assign pop           = in_upd && i_ftb_update_finished;

    ftb_upd_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .ovr       (coal),
        .wr_pc     (i_update_pc),
        .wr_info   (i_update_info),
        .cmp_pc    (i_update_pc),
        .tail_hit  (tail_hit),
        .head_pc   (head_pc),
        .head_info (head_info),
        .count     (count)
    );

    // Next-state: issue from IDLE on sel_upd, release the port on finish.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (sel_upd) state_d = ST_UPD;
            ST_UPD:  if (i_ftb_update_finished) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any update in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Starve counter: granted lookups while updates wait, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (q_empty || sel_upd) begin
            starve_q <= '0;
        end else if (lookup_gnt && starve_q != STARVE_MAX) begin
            starve_q <= starve_q + SW'(1);
        end
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        o_update_rdy      = rst_n && !q_full;
        o_lookup_gnt      = rst_n && lookup_gnt;
        o_ftb_update_req  = rst_n && in_upd;
        o_pred_hold       = rst_n && in_upd;
        o_ftb_update_pc   = rst_n ? head_pc : '0;
        o_ftb_update_info = rst_n ? head_info : '0;
        o_q_count         = rst_n ? count : '0;
    end

endmodule

// File: tb/tb_ftb_update_sched.sv
// Self-checking bench for ftb_update_sched: a per-cycle vector table for
// drain and coalescing, hand sequences for starvation, full, in-flight
// appends and reset, and an update scoreboard checked at each issue.
module tb_ftb_update_sched;
    import ftb_update_sched_pkg::*;

    localparam int CW = $clog2(FTB_UPDQ_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_update_vld = 1'b0;
    logic              o_update_rdy;
    logic [XDEF_W-1:0] i_update_pc = '0;
    ftbInfo_t          i_update_info = '0;
    logic              i_lookup_req = 1'b0;
    logic              o_lookup_gnt;
    logic              o_ftb_update_req;
    logic [XDEF_W-1:0] o_ftb_update_pc;
    ftbInfo_t          o_ftb_update_info;
    logic              i_ftb_update_finished = 1'b0;
    logic              o_pred_hold;
    logic [CW-1:0]     o_q_count;

    ftb_update_sched #(
        .QDEPTH       (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_update_vld          (i_update_vld),
        .o_update_rdy          (o_update_rdy),
        .i_update_pc           (i_update_pc),
        .i_update_info         (i_update_info),
        .i_lookup_req          (i_lookup_req),
        .o_lookup_gnt          (o_lookup_gnt),
        .o_ftb_update_req      (o_ftb_update_req),
        .o_ftb_update_pc       (o_ftb_update_pc),
        .o_ftb_update_info     (o_ftb_update_info),
        .i_ftb_update_finished (i_ftb_update_finished),
        .o_pred_hold           (o_pred_hold),
        .o_q_count             (o_q_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [XDEF_W-1:0] pc;
        ftbInfo_t          info;
    } upd_t;

    upd_t sb[$];

    typedef struct {
        logic              vld;
        logic [XDEF_W-1:0] pc;
        int                ctr;
        logic              lk;
        logic              fin;
        int                sb_op;   // 0 none, 1 push, 2 overwrite youngest
        logic              e_rdy;
        logic              e_gnt;
        logic              e_req;
        logic [CW-1:0]     e_cnt;
    } vec_t;

    vec_t vt[11];

    function automatic ftbInfo_t mk_info(input int c);
        ftbInfo_t f;
        f.valid        = 1'b1;
        f.tag          = 12'(c * 37 + 5);
        f.tgt          = 20'(c * 4099 + 1);
        f.ctr0         = 2'(c);
        f.ctr1         = 2'(c >> 2);
        f.always_taken = c[0];
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [XDEF_W-1:0] pc, input int c,
                         input logic lk, input logic fin);
        i_update_vld          = vld;
        i_update_pc           = pc;
        i_update_info         = mk_info(c);
        i_lookup_req          = lk;
        i_ftb_update_finished = fin;
    endtask

    task automatic sb_push(input logic [XDEF_W-1:0] pc, input int c);
        upd_t e;
        e.pc   = pc;
        e.info = mk_info(c);
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rdy"},  64'(o_update_rdy), 64'd0);
        chk({tag, " gnt"},  64'(o_lookup_gnt), 64'd0);
        chk({tag, " req"},  64'(o_ftb_update_req), 64'd0);
        chk({tag, " hold"}, 64'(o_pred_hold), 64'd0);
        chk({tag, " pc"},   64'(o_ftb_update_pc), 64'd0);
        chk({tag, " info"}, 64'(o_ftb_update_info), 64'd0);
        chk({tag, " cnt"},  64'(o_q_count), 64'd0);
    endtask

    // Counts lookup grants until an update is issued; returns at the
    // falling edge of the first cycle with the update request high.
    task automatic wait_upd(output int g);
        bit seen;
        seen = 1'b0;
        g = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (o_ftb_update_req) begin
                seen = 1'b1;
            end else begin
                if (o_lookup_gnt) g++;
                tick();
            end
        end
        chk("update issued within budget", 64'(seen), 64'd1);
    endtask

    task automatic drain(input string tag);
        drive(1'b0, '0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 40 && o_q_count != '0; k++) tick();
        chk({tag, " drained cnt"}, 64'(o_q_count), 64'd0);
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        tick();
    endtask

    // Scoreboard: each newly issued update must match the oldest expected one.
    initial begin
        logic prev_req;
        upd_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (o_ftb_update_req && !prev_req) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb unexpected update: got pc 0x%0h, expected none", o_ftb_update_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb update pc", 64'(o_ftb_update_pc), 64'(e.pc));
                    chk("sb update info", 64'(o_ftb_update_info), 64'(e.info));
                end
            end
            prev_req = o_ftb_update_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;

        //            vld   pc                 ctr lk    fin   op rdy   gnt   req   cnt
        vt[0]  = '{1'b1, 39'h0_8000_0000, 1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 39'h0,           0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 3'd1};
        vt[2]  = '{1'b0, 39'h0,           0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 3'd1};
        vt[3]  = '{1'b0, 39'h0,           0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 3'd1};
        vt[4]  = '{1'b0, 39'h0,           0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 3'd1};
        vt[5]  = '{1'b0, 39'h0,           0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 3'd0};
        vt[6]  = '{1'b1, 39'h1040,        1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 3'd0};
        vt[7]  = '{1'b1, 39'h1040,        2, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 3'd1};
        vt[8]  = '{1'b0, 39'h0,           0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 3'd1};
        vt[9]  = '{1'b0, 39'h0,           0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 3'd1};
        vt[10] = '{1'b0, 39'h0,           0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 3'd0};

        // Reset: outputs low even with requests pending on the inputs.
        rst_n = 1'b0;
        drive(1'b1, 39'h7000, 5, 1'b1, 1'b1);
        @(negedge clk);
        chk_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post-reset rdy", 64'(o_update_rdy), 64'd1);
        chk("post-reset cnt", 64'(o_q_count), 64'd0);
        chk("post-reset req", 64'(o_ftb_update_req), 64'd0);
        tick();

        // Idle drain and tail coalescing.
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].vld, vt[i].pc, vt[i].ctr, vt[i].lk, vt[i].fin);
            if (vt[i].sb_op == 1) begin
                sb_push(vt[i].pc, vt[i].ctr);
            end else if (vt[i].sb_op == 2) begin
                sb[sb.size() - 1].info = mk_info(vt[i].ctr);
            end
            @(negedge clk);
            chk($sformatf("vec%0d rdy", i),  64'(o_update_rdy), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d gnt", i),  64'(o_lookup_gnt), 64'(vt[i].e_gnt));
            chk($sformatf("vec%0d req", i),  64'(o_ftb_update_req), 64'(vt[i].e_req));
            chk($sformatf("vec%0d hold", i), 64'(o_pred_hold), 64'(vt[i].e_req));
            chk($sformatf("vec%0d cnt", i),  64'(o_q_count), 64'(vt[i].e_cnt));
            tick();
        end

        // Starvation: exactly 8 grants, and the counter restarts after an issue.
        drive(1'b1, 39'h2000, 1, 1'b1, 1'b0);
        sb_push(39'h2000, 1);
        tick();
        drive(1'b0, '0, 0, 1'b1, 1'b0);
        wait_upd(g);
        chk("starve grants first", 64'(g), 64'd8);
        chk("starve gnt during upd", 64'(o_lookup_gnt), 64'd0);
        drive(1'b1, 39'h2040, 2, 1'b1, 1'b0);
        sb_push(39'h2040, 2);
        tick();
        drive(1'b0, '0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("starve req held", 64'(o_ftb_update_req), 64'd1);
        chk("starve cnt 2", 64'(o_q_count), 64'd2);
        tick();
        drive(1'b0, '0, 0, 1'b1, 1'b0);
        wait_upd(g);
        chk("starve grants after clear", 64'(g), 64'd8);
        drive(1'b0, '0, 0, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 0, 1'b1, 1'b0);
        @(negedge clk);
        chk("starve empty cnt", 64'(o_q_count), 64'd0);
        chk("starve empty gnt", 64'(o_lookup_gnt), 64'd1);
        tick();

        // Full: update forced by a full queue; a held 5th request waits for
        // the cycle after the pop.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 39'(39'h3000 + i * 'h40), 10 + i, 1'b1, 1'b0);
            sb_push(39'(39'h3000 + i * 'h40), 10 + i);
            @(negedge clk);
            chk($sformatf("fill%0d rdy", i), 64'(o_update_rdy), 64'd1);
            chk($sformatf("fill%0d gnt", i), 64'(o_lookup_gnt), 64'd1);
            chk($sformatf("fill%0d cnt", i), 64'(o_q_count), 64'(i));
            tick();
        end
        drive(1'b1, 39'h3100, 20, 1'b1, 1'b0);
        @(negedge clk);
        chk("full rdy", 64'(o_update_rdy), 64'd0);
        chk("full gnt", 64'(o_lookup_gnt), 64'd0);
        chk("full cnt", 64'(o_q_count), 64'd4);
        tick();
        drive(1'b1, 39'h3100, 20, 1'b1, 1'b1);
        @(negedge clk);
        chk("full forced req", 64'(o_ftb_update_req), 64'd1);
        chk("full rdy at pop", 64'(o_update_rdy), 64'd0);
        tick();
        drive(1'b1, 39'h3100, 20, 1'b1, 1'b0);
        sb_push(39'h3100, 20);
        @(negedge clk);
        chk("after pop rdy", 64'(o_update_rdy), 64'd1);
        chk("after pop cnt", 64'(o_q_count), 64'd3);
        tick();
        drive(1'b0, '0, 0, 1'b1, 1'b0);
        @(negedge clk);
        chk("5th accepted cnt", 64'(o_q_count), 64'd4);
        tick();
        drain("full");

        // In-flight entry is never a coalescing target.
        drive(1'b1, 39'h5000, 1, 1'b0, 1'b0);
        sb_push(39'h5000, 1);
        tick();
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("inflight pre req", 64'(o_ftb_update_req), 64'd0);
        tick();
        drive(1'b1, 39'h5000, 2, 1'b0, 1'b0);
        sb_push(39'h5000, 2);
        @(negedge clk);
        chk("inflight req", 64'(o_ftb_update_req), 64'd1);
        tick();
        drive(1'b0, '0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("inflight append cnt", 64'(o_q_count), 64'd2);
        tick();
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("inflight idle req", 64'(o_ftb_update_req), 64'd0);
        chk("inflight idle cnt", 64'(o_q_count), 64'd1);
        tick();
        drive(1'b1, 39'h5000, 3, 1'b0, 1'b1);
        sb_push(39'h5000, 3);
        @(negedge clk);
        chk("enq+pop req", 64'(o_ftb_update_req), 64'd1);
        tick();
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("enq+pop cnt", 64'(o_q_count), 64'd1);
        chk("enq+pop idle req", 64'(o_ftb_update_req), 64'd0);
        tick();
        drain("inflight");

        // Reset while an update is in flight with entries queued behind it.
        drive(1'b1, 39'h6000, 1, 1'b0, 1'b0);
        sb_push(39'h6000, 1);
        tick();
        drive(1'b1, 39'h6040, 2, 1'b0, 1'b0);
        sb_push(39'h6040, 2);
        tick();
        drive(1'b1, 39'h6080, 3, 1'b0, 1'b0);
        sb_push(39'h6080, 3);
        tick();
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre-reset req", 64'(o_ftb_update_req), 64'd1);
        chk("pre-reset cnt", 64'(o_q_count), 64'd3);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 39'h6100, 4, 1'b1, 1'b0);
        sb.delete();
        @(negedge clk);
        chk_zero("mid-upd reset");
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst cnt", 64'(o_q_count), 64'd0);
        chk("rst rdy", 64'(o_update_rdy), 64'd1);
        chk("rst req", 64'(o_ftb_update_req), 64'd0);
        chk("rst hold", 64'(o_pred_hold), 64'd0);
        tick();
        @(negedge clk);
        chk("stray fin cnt", 64'(o_q_count), 64'd0);
        chk("stray fin req", 64'(o_ftb_update_req), 64'd0);
        tick();
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        tick();

        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
